// File: rtl/fetch_queue_pkg.sv
// Shared types for the dual-issue fetch queue.
// Entry layout and the NOP filler for empty decode slots.
package fetch_queue_pkg;

    localparam logic [31:0] FQ_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage: two write ports, two async read ports.
// The data array carries no reset; validity lives in the counter.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  fq_entry_t       wd1,
    input  logic            we2,
    input  logic [AW-1:0]   wa2,
    input  fq_entry_t       wd2,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output fq_entry_t       rd1,
    output fq_entry_t       rd2
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we1) mem[wa1] <= wd1;
        if (we2) mem[wa2] <= wd2;
    end

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer, two in / up to two out.
// Holds pointers, occupancy, stall and flush control.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ValidF1,
    input  logic          ValidF2,
    input  logic [31:0]   InstrF1,
    input  logic [31:0]   PCF1,
    input  logic [31:0]   PCPlus4F1,
    input  logic [31:0]   InstrF2,
    input  logic [31:0]   PCF2,
    input  logic [31:0]   PCPlus4F2,
    input  logic [1:0]    PopD,
    input  logic          Flush,
    output logic          StallF,
    output logic          ValidD1,
    output logic          ValidD2,
    output logic [31:0]   InstrD1,
    output logic [31:0]   PCD1,
    output logic [31:0]   PCPlus4D1,
    output logic [31:0]   InstrD2,
    output logic [31:0]   PCD2,
    output logic [31:0]   PCPlus4D2,
    output logic [CW-1:0] Count
);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [1:0]    push_n;
    logic [1:0]    pop_req;
    logic [1:0]    pop_n;
    fq_entry_t     wd1, wd2;
    fq_entry_t     rd1, rd2;

    // Stall looks only at registered occupancy; same-cycle pops earn no credit.
    assign StallF  = count_q > CW'(DEPTH - 2);
    assign push_n  = (StallF || !ValidF1) ? 2'd0
                   : (ValidF2 ? 2'd2 : 2'd1);
    assign pop_req = (PopD == 2'd3) ? 2'd2 : PopD;
    assign pop_n   = (CW'(pop_req) > count_q) ? count_q[1:0]
                   : pop_req;

    assign wd1 = '{instr: InstrF1, pc: PCF1, pcplus4: PCPlus4F1};
    assign wd2 = '{instr: InstrF2, pc: PCF2, pcplus4: PCPlus4F2};

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk (clk),
        .we1 (push_n != 2'd0 && !Flush),
        .wa1 (wr_ptr),
        .wd1 (wd1),
        .we2 (push_n == 2'd2 && !Flush),
        .wa2 (wr_ptr + AW'(1)),
        .wd2 (wd2),
        .ra1 (rd_ptr),
        .ra2 (rd_ptr + AW'(1)),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (Flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr + AW'(pop_n);
            wr_ptr  <= wr_ptr + AW'(push_n);
            count_q <= count_q + CW'(push_n) - CW'(pop_n);
        end
    end

    assign ValidD1 = count_q != '0;
    assign ValidD2 = count_q > CW'(1);
    assign Count   = count_q;

    always_comb begin
        InstrD1   = FQ_NOP;
        PCD1      = '0;
        PCPlus4D1 = '0;
        InstrD2   = FQ_NOP;
        PCD2      = '0;
        PCPlus4D2 = '0;
        if (ValidD1) begin
            InstrD1   = rd1.instr;
            PCD1      = rd1.pc;
            PCPlus4D1 = rd1.pcplus4;
        end
        if (ValidD2) begin
            InstrD2   = rd2.instr;
            PCD2      = rd2.pc;
            PCPlus4D2 = rd2.pcplus4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based model.
// Directed phases pin the model with literal expectations.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    logic ValidF1, ValidF2;
    logic [31:0] InstrF1, PCF1, PCPlus4F1;
    logic [31:0] InstrF2, PCF2, PCPlus4F2;
    logic [1:0] PopD;
    logic Flush;
    logic StallF, ValidD1, ValidD2;
    logic [31:0] InstrD1, PCD1, PCPlus4D1;
    logic [31:0] InstrD2, PCD2, PCPlus4D2;
    logic [CW-1:0] Count;

    int tests = 0;
    int fails = 0;
    logic [31:0] pc_gen = 0;
    fq_entry_t mq[$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ValidF1(ValidF1), .ValidF2(ValidF2),
        .InstrF1(InstrF1), .PCF1(PCF1), .PCPlus4F1(PCPlus4F1),
        .InstrF2(InstrF2), .PCF2(PCF2), .PCPlus4F2(PCPlus4F2),
        .PopD(PopD), .Flush(Flush), .StallF(StallF),
        .ValidD1(ValidD1), .ValidD2(ValidD2),
        .InstrD1(InstrD1), .PCD1(PCD1), .PCPlus4D1(PCPlus4D1),
        .InstrD2(InstrD2), .PCD2(PCD2), .PCPlus4D2(PCPlus4D2),
        .Count(Count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit model_stall();
        return (DEPTH - mq.size()) < 2;
    endfunction

    task automatic compare_all();
        fq_entry_t e1, e2;
        int n;
        n  = mq.size();
        e1 = '{instr: FQ_NOP, pc: 32'h0, pcplus4: 32'h0};
        e2 = e1;
        if (n >= 1) e1 = mq[0];
        if (n >= 2) e2 = mq[1];
        chk("count", 32'(Count), 32'(n));
        chk("stall", 32'(StallF), 32'(model_stall()));
        chk("valid_d1", 32'(ValidD1), 32'(n >= 1));
        chk("valid_d2", 32'(ValidD2), 32'(n >= 2));
        chk("instr_d1", InstrD1, e1.instr);
        chk("pc_d1", PCD1, e1.pc);
        chk("pc4_d1", PCPlus4D1, e1.pcplus4);
        chk("instr_d2", InstrD2, e2.instr);
        chk("pc_d2", PCD2, e2.pc);
        chk("pc4_d2", PCPlus4D2, e2.pcplus4);
    endtask

    task automatic model_update();
        int n;
        bit st;
        if (Flush) begin
            mq.delete();
        end else begin
            st = model_stall();
            n = (PopD == 2'd3) ? 2 : int'(PopD);
            if (n > mq.size()) n = mq.size();
            repeat (n) void'(mq.pop_front());
            if (!st && ValidF1) begin
                mq.push_back('{instr: InstrF1, pc: PCF1,
                               pcplus4: PCPlus4F1});
                if (ValidF2)
                    mq.push_back('{instr: InstrF2, pc: PCF2,
                                   pcplus4: PCPlus4F2});
            end
        end
    endtask

    // Called at a falling edge; drives, clocks, then checks.
    task automatic step(input logic v1, input logic v2,
                        input logic [1:0] pd, input logic fl);
        ValidF1   = v1;
        ValidF2   = v2;
        PopD      = pd;
        Flush     = fl;
        InstrF1   = $urandom;
        InstrF2   = $urandom;
        PCF1      = pc_gen;
        PCPlus4F1 = pc_gen + 32'd4;
        PCF2      = pc_gen + 32'd4;
        PCPlus4F2 = pc_gen + 32'd8;
        if (v1 && !fl && !model_stall())
            pc_gen = pc_gen + (v2 ? 32'd8 : 32'd4);
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst = 1'b0;
        ValidF1 = 0; ValidF2 = 0; PopD = 0; Flush = 0;
        InstrF1 = 0; PCF1 = 0; PCPlus4F1 = 0;
        InstrF2 = 0; PCF2 = 0; PCPlus4F2 = 0;
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_instr_d1", InstrD1, 32'h0000_0013);
        rst = 1'b1;
        #1 compare_all();
        @(negedge clk);

        // First pair: literal pins on latency and payload.
        ValidF1 = 1; ValidF2 = 1; PopD = 0; Flush = 0;
        InstrF1 = 32'h0010_0093; PCF1 = 0; PCPlus4F1 = 4;
        InstrF2 = 32'h0020_0113; PCF2 = 4; PCPlus4F2 = 8;
        @(posedge clk);
        model_update();
        pc_gen = 8;
        @(negedge clk);
        compare_all();
        chk("lit_instr_d1", InstrD1, 32'h0010_0093);
        chk("lit_pc_d1", PCD1, 32'h0);
        chk("lit_pc4_d2", PCPlus4D2, 32'h8);
        chk("lit_count2", 32'(Count), 32'd2);

        // Fill to full, push while stalled, then drain a pair.
        repeat (3) step(1, 1, 2'd0, 0);
        chk("lit_full", 32'(Count), 32'd8);
        chk("lit_stall", 32'(StallF), 32'd1);
        step(1, 1, 2'd0, 0);
        chk("lit_hold_full", 32'(Count), 32'd8);
        step(0, 0, 2'd2, 0);
        chk("lit_drain", 32'(Count), 32'd6);
        chk("lit_unstall", 32'(StallF), 32'd0);

        // Steady 2-in/2-out across the index wrap.
        step(0, 0, 2'd0, 1);
        pc_gen = 0;
        step(1, 1, 2'd0, 0);
        chk("lit_steady_pc0", PCD1, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            step(1, 1, 2'd2, 0);
            chk("lit_steady_pc", PCD1, 32'(8 * k));
            chk("lit_steady_cnt", 32'(Count), 32'd2);
        end

        // Over-pop at Count=1 with PopD=3.
        step(0, 0, 2'd1, 0);
        step(0, 0, 2'd3, 0);
        chk("lit_overpop_cnt", 32'(Count), 32'd0);
        chk("lit_overpop_nop", InstrD1, 32'h0000_0013);

        // Flush with a same-cycle push and pop at Count=5.
        step(1, 1, 2'd0, 0);
        step(1, 1, 2'd0, 0);
        step(1, 0, 2'd0, 0);
        chk("lit_cnt5", 32'(Count), 32'd5);
        step(1, 1, 2'd1, 1);
        chk("lit_flush_cnt", 32'(Count), 32'd0);
        chk("lit_flush_v1", 32'(ValidD1), 32'd0);
        chk("lit_flush_stall", 32'(StallF), 32'd0);
        step(0, 0, 2'd0, 0);

        // Single pushes interleaved with pops.
        for (int i = 0; i < 12; i++)
            step(1, 0, 2'($urandom_range(0, 1)), 0);

        // Asynchronous reset in the middle of a cycle.
        ValidF1 = 0; ValidF2 = 0; PopD = 0; Flush = 0;
        #2 rst = 1'b0;
        #1;
        mq.delete();
        compare_all();
        chk("lit_arst_v1", 32'(ValidD1), 32'd0);
        chk("lit_arst_nop", InstrD1, 32'h0000_0013);
        #1 rst = 1'b1;
        @(negedge clk);
        compare_all();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic v1, v2, fl;
            v1 = ($urandom_range(0, 3) != 0);
            v2 = $urandom_range(0, 1);
            fl = ($urandom_range(0, 24) == 0);
            step(v1, v2, 2'($urandom_range(0, 3)), fl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Dual-issue instruction buffer between the two-wide fetch stage and decode. Each cycle it accepts up to two fetched instructions, with their PC and PC+4, and presents the two oldest entries to decode. Decode retires 0, 1 or 2 entries per cycle. The queue back-pressures fetch through a stall output and is emptied in one cycle on a control-flow redirect from execute.

## Interface
- DEPTH, 8, number of entries; power of two, ≥4
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low; clears all state
- ValidF1  in  1  fetch slot 1 carries an instruction
- ValidF2  in  1  fetch slot 2 carries an instruction; meaningful only when ValidF1=1
- InstrF1, PCF1, PCPlus4F1  in  32 each  fetch slot 1 payload (older)
- InstrF2, PCF2, PCPlus4F2  in  32 each  fetch slot 2 payload (younger)
- PopD  in  2  number of head entries decode consumes this cycle (0..3)
- Flush  in  1  redirect from execute; discard all entries
- StallF  out  1  queue cannot accept a pair; fetch must hold (drives fetch en1/en2 low)
- ValidD1, ValidD2  out  1 each  head / head+1 entry is valid
- InstrD1, PCD1, PCPlus4D1  out  32 each  head entry payload
- InstrD2, PCD2, PCPlus4D2  out  32 each  head+1 entry payload
- Count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular buffer with a read pointer (rd_ptr), a write pointer (wr_ptr), each $clog2(DEPTH) bits and wrapping modulo DEPTH, and an occupancy counter Count.
- Push count is ValidF1 + (ValidF1 & ValidF2).
  - ValidF2 without ValidF1 pushes nothing.
  - Slot 1 is written at wr_ptr and slot 2 at wr_ptr+1, both modulo DEPTH.
  - The push is ignored entirely while StallF=1.
- StallF = (DEPTH − Count) < 2. It is computed from registered Count only and does not credit same-cycle pops.
- Effective pop = min(PopD saturated to 2, Count).
  - PopD=3 is treated as 2.
  - Popping beyond occupancy is silently clipped.
  - rd_ptr advances by the effective pop.
- Next Count = Count + push − pop. With StallF gating, the result never exceeds DEPTH or underflows.
- Flush has priority over push and pop in the same cycle. Next state: rd_ptr = wr_ptr = 0, Count = 0. Same-cycle fetch data is dropped.
- Head outputs are combinational reads of the registered storage:
  - ValidD1 = Count≥1; ValidD2 = Count≥2.
  - An invalid output slot drives Instr = 32'h0000_0013 (NOP) and PC = PCPlus4 = 0.
- Program order is preserved: slot 1 is always older than slot 2, and queue order equals push order.

## Timing
- Reset (rst=0, asynchronous): Count=0, pointers=0, ValidD1=ValidD2=0, StallF=0, InstrD*=32'h0000_0013, PCD*=PCPlus4D*=0. This holds until the first rising edge after rst deasserts.
- Latency: an instruction pushed at edge N is visible on the D-side outputs in the cycle after edge N. There is no bypass from F to D while the queue is empty.
- A pop takes effect at the edge. Next-head data appears in the following cycle.
- Simultaneous push and pop in one cycle are legal, including at full−2 and at Count=1.
- Wrap-around: a pair straddling index DEPTH−1 → 0 is stored and presented correctly.
- A Flush asserted in cycle N gives Count=0, ValidD*=0 and StallF=0 in cycle N+1. Fetch may push again in cycle N+1.
- Asynchronous reset mid-operation discards all entries immediately, without waiting for a clock edge.

## Structure
- The shared package defines:
  - `fq_entry_t`: packed struct {instr[31:0], pc[31:0], pcplus4[31:0]}.
  - The NOP constant 32'h0000_0013.
- The natural sub-module is `fetch_queue_mem`: DEPTH×`fq_entry_t` array with 2 synchronous write ports and 2 asynchronous read ports, written at the edge and with no reset on the data array.
- The top level holds the pointers, counter, stall and flush logic.

## Test plan
- Reset release, push pair (I0@0x0, I1@0x4) → the next cycle shows ValidD1=ValidD2=1, InstrD1=I0, PCD1=0x0, PCPlus4D2=0x8, Count=2.
- Push pairs with PopD=0 until full (DEPTH=8) → StallF=1 once Count=7 or 8. A further push with StallF=1 leaves Count unchanged. Then PopD=2 → Count drops by 2 and StallF clears when Count≤6.
- Steady push 2 / pop 2 for 20 cycles crossing the index 7→0 wrap → PCD1 sequence 0x0, 0x8, 0x10, … with no gaps; Count stays 2.
- Count=1 with PopD=2 (or PopD=3) → one entry removed, Count=0, ValidD1=0, InstrD1=0x00000013.
- Flush asserted together with a push and PopD=1 at Count=5 → next cycle Count=0, ValidD1=0, StallF=0; no flushed or same-cycle instruction ever appears.
- ValidF1=1, ValidF2=0 repeatedly, interleaved with pops, then assert rst asynchronously mid-cycle → single entries are ordered correctly; all outputs reach reset values before the next edge.
